// File: rtl/mem_interface_if.sv
// Bus and handshake bundle between the LC-3 control/datapath, the memory
// access stage and the memory itself.
interface mem_interface_if;
    logic [15:0] bus;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        r;
    logic        err;

    // master: the access stage, which drives the memory request
    modport master (
        input  bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mar_out, mdr_out, r, err
    );

    // slave: control FSM, datapath and memory model around the stage
    modport slave (
        output bus, ld_mar, ld_mdr, mio_en, r_w, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mar_out, mdr_out, r, err
    );
endinterface

// File: rtl/mem_interface.sv
// LC-3 memory access stage: MAR/MDR registers plus a req/ack handshake with
// optional timeout; pulses r for one cycle per completed access.
module mem_interface #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_interface_if.master  mif
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [15:0]      mar;
    logic [15:0]      mdr;
    logic             we;
    logic             err;
    logic             arm;
    logic             req;
    logic             rdy;
    logic [CNT_W-1:0] cnt;
    logic             ld_ok;

    // Bus loads are blocked during REQ so address and write data stay stable
    assign ld_ok = (state != ST_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mar   <= 16'h0000;
            mdr   <= 16'h0000;
            we    <= 1'b0;
            err   <= 1'b0;
            arm   <= 1'b1;
            req   <= 1'b0;
            rdy   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (ld_ok && mif.ld_mar) mar <= mif.bus;
            if (ld_ok && mif.ld_mdr && !mif.mio_en) mdr <= mif.bus;

            case (state)
                ST_IDLE: begin
                    if (mif.mio_en && arm) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                        we    <= mif.r_w;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // ack takes priority over a timeout on the same edge
                    if (mif.mem_ack) begin
                        state <= ST_DONE;
                        req   <= 1'b0;
                        rdy   <= 1'b1;
                        if (!we) mdr <= mif.mem_rdata;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        state <= ST_DONE;
                        req   <= 1'b0;
                        rdy   <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    rdy   <= 1'b0;
                    arm   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                    rdy   <= 1'b0;
                end
            endcase

            // Seeing mio_en low re-arms; this wins over the clear in DONE
            if (!mif.mio_en) arm <= 1'b1;
        end
    end

    assign mif.mem_req   = req;
    assign mif.mem_we    = we;
    assign mif.mem_addr  = mar;
    assign mif.mem_wdata = mdr;
    assign mif.mar_out   = mar;
    assign mif.mdr_out   = mdr;
    assign mif.r         = rdy;
    assign mif.err       = err;
endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: per-cycle vector table on a default
// instance, plus hand sequences for timeout and asynchronous abort.
module tb_mem_interface;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_bad;

    mem_interface_if ifa ();
    mem_interface_if ifb ();

    mem_interface dut_a (
        .clk   (clk),
        .rst_n (rst_a),
        .mif   (ifa)
    );

    mem_interface #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_b),
        .mif   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld_mar;
        logic        ld_mdr;
        logic        mio_en;
        logic        r_w;
        logic        ack;
        logic [15:0] bus;
        logic [15:0] rdata;
        logic        req;
        logic        we;
        logic        r;
        logic        err;
        logic [15:0] mar;
        logic [15:0] mdr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ld_mar, input logic ld_mdr, input logic mio_en,
                       input logic r_w, input logic ack, input logic [15:0] bus,
                       input logic [15:0] rdata, input logic req, input logic we,
                       input logic r, input logic err, input logic [15:0] mar,
                       input logic [15:0] mdr);
        vec_t v;
        v.ld_mar = ld_mar; v.ld_mdr = ld_mdr; v.mio_en = mio_en; v.r_w = r_w;
        v.ack = ack; v.bus = bus; v.rdata = rdata; v.req = req; v.we = we;
        v.r = r; v.err = err; v.mar = mar; v.mdr = mdr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input vec_t v);
        chk({tag, " mem_req"},   16'(ifa.mem_req), 16'(v.req));
        chk({tag, " mem_we"},    16'(ifa.mem_we),  16'(v.we));
        chk({tag, " r"},         16'(ifa.r),       16'(v.r));
        chk({tag, " err"},       16'(ifa.err),     16'(v.err));
        chk({tag, " mem_addr"},  ifa.mem_addr,     v.mar);
        chk({tag, " mar_out"},   ifa.mar_out,      v.mar);
        chk({tag, " mdr_out"},   ifa.mdr_out,      v.mdr);
        chk({tag, " mem_wdata"}, ifa.mem_wdata,    v.mdr);
    endtask

    initial begin
        vec_t z;
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        {ifa.ld_mar, ifa.ld_mdr, ifa.mio_en, ifa.r_w, ifa.mem_ack} = '0;
        ifa.bus = 16'h0; ifa.mem_rdata = 16'h0;
        {ifb.ld_mar, ifb.ld_mdr, ifb.mio_en, ifb.r_w, ifb.mem_ack} = '0;
        ifb.bus = 16'h0; ifb.mem_rdata = 16'h0;

        //   ldmar ldmdr mio rw ack bus       rdata     req we r err mar       mdr
        // read with ack on the third cycle after mem_req rises
        add(1, 0, 0, 0, 0, 16'h3000, 16'h0000, 0, 0, 0, 0, 16'h3000, 16'h0000);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h3000, 16'h0000);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h3000, 16'h0000);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h3000, 16'h0000);
        add(0, 0, 1, 0, 1, 16'h0000, 16'hBEEF, 0, 0, 1, 0, 16'h3000, 16'hBEEF);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h3000, 16'hBEEF);
        // write, ack in first REQ cycle; read data must not land in MDR
        add(1, 0, 0, 0, 0, 16'h4001, 16'h0000, 0, 0, 0, 0, 16'h4001, 16'hBEEF);
        add(0, 1, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 1, 1, 16'h0000, 16'hDEAD, 0, 1, 1, 0, 16'h4001, 16'h1234);
        // mio_en held high: no retrigger; ld_mdr with mio_en is ignored
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h4001, 16'h1234);
        add(0, 1, 1, 1, 0, 16'hAAAA, 16'h0000, 0, 1, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h4001, 16'h1234);
        // drop one cycle, then a new read; ld_mar/ld_mdr during REQ ignored
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 16'h4001, 16'h1234);
        add(1, 1, 1, 0, 0, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 16'h4001, 16'h1234);
        add(0, 0, 1, 0, 1, 16'h0000, 16'h0F0F, 0, 0, 1, 0, 16'h4001, 16'h0F0F);
        // ack outside REQ is ignored
        add(0, 0, 0, 0, 1, 16'h0000, 16'h5A5A, 0, 0, 0, 0, 16'h4001, 16'h0F0F);
        // ld_mar on the start edge: access uses the new address
        add(1, 0, 1, 0, 0, 16'h5000, 16'h0000, 1, 0, 0, 0, 16'h5000, 16'h0F0F);
        add(0, 0, 1, 0, 1, 16'h0000, 16'h1111, 0, 0, 1, 0, 16'h5000, 16'h1111);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h5000, 16'h1111);

        repeat (2) @(posedge clk);
        #1;
        z = '{default: '0};
        chk_a("reset", z);

        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            ifa.ld_mar = vq[i].ld_mar; ifa.ld_mdr = vq[i].ld_mdr;
            ifa.mio_en = vq[i].mio_en; ifa.r_w = vq[i].r_w;
            ifa.mem_ack = vq[i].ack; ifa.bus = vq[i].bus; ifa.mem_rdata = vq[i].rdata;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vq[i]);
        end

        // asynchronous abort mid-REQ
        @(negedge clk);
        ifa.mio_en = 1'b1; ifa.r_w = 1'b0; ifa.mem_ack = 1'b0;
        @(posedge clk);
        #1 chk("abort req_up", 16'(ifa.mem_req), 16'h1);
        #2 rst_a = 1'b0;
        #1 chk("abort req_async", 16'(ifa.mem_req), 16'h0);
        chk("abort r_async", 16'(ifa.r), 16'h0);
        chk("abort mar_async", ifa.mar_out, 16'h0000);
        @(posedge clk);
        #1 chk("abort r_edge", 16'(ifa.r), 16'h0);
        @(negedge clk);
        rst_a = 1'b1;
        ifa.mio_en = 1'b0;
        @(posedge clk);
        #1 chk("abort r_after", 16'(ifa.r), 16'h0);
        chk("abort req_after", 16'(ifa.mem_req), 16'h0);

        // timeout on the 4-cycle instance; MDR keeps its old value
        @(negedge clk);
        ifb.ld_mdr = 1'b1; ifb.bus = 16'h5555;
        @(posedge clk);
        #1 chk("to mdr_load", ifb.mdr_out, 16'h5555);
        @(negedge clk);
        ifb.ld_mdr = 1'b0; ifb.bus = 16'h0000;
        ifb.mio_en = 1'b1; ifb.r_w = 1'b0; ifb.mem_ack = 1'b0; ifb.mem_rdata = 16'h6666;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk($sformatf("to req_c%0d", k + 1), 16'(ifb.mem_req), 16'h1);
            chk($sformatf("to r_c%0d", k + 1), 16'(ifb.r), 16'h0);
        end
        @(posedge clk);
        #1 chk("to req_end", 16'(ifb.mem_req), 16'h0);
        chk("to r", 16'(ifb.r), 16'h1);
        chk("to err", 16'(ifb.err), 16'h1);
        chk("to mdr_kept", ifb.mdr_out, 16'h5555);
        @(negedge clk);
        ifb.mio_en = 1'b0;
        @(posedge clk);
        #1 chk("to r_drop", 16'(ifb.r), 16'h0);
        chk("to err_sticky", 16'(ifb.err), 16'h1);
        @(negedge clk);
        ifb.mio_en = 1'b1;
        @(posedge clk);
        #1 chk("to req_again", 16'(ifb.mem_req), 16'h1);
        chk("to err_clear", 16'(ifb.err), 16'h0);
        @(negedge clk);
        ifb.mem_ack = 1'b1; ifb.mem_rdata = 16'h7777;
        @(posedge clk);
        #1 chk("to good_r", 16'(ifb.r), 16'h1);
        chk("to good_err", 16'(ifb.err), 16'h0);
        chk("to good_mdr", ifb.mdr_out, 16'h7777);

        // ack on the same edge as the timeout: ack wins
        @(negedge clk);
        ifb.mem_ack = 1'b0; ifb.mio_en = 1'b0;
        @(negedge clk);
        ifb.mio_en = 1'b1;
        @(posedge clk);
        #1 chk("tie req_c1", 16'(ifb.mem_req), 16'h1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 chk($sformatf("tie req_c%0d", k + 2), 16'(ifb.mem_req), 16'h1);
        end
        @(negedge clk);
        ifb.mem_ack = 1'b1; ifb.mem_rdata = 16'h9999;
        @(posedge clk);
        #1 chk("tie r", 16'(ifb.r), 16'h1);
        chk("tie err", 16'(ifb.err), 16'h0);
        chk("tie mdr", ifb.mdr_out, 16'h9999);
        @(negedge clk);
        ifb.mem_ack = 1'b0; ifb.mio_en = 1'b0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
